// File: rtl/rx_byte_assembler.sv
// rx_byte_assembler: strips USB bit stuffing from NRZI-decoded receive bits,
// packs them LSB-first into bytes and hands each byte or framing event
// (start, stop, stream, stuff error) to the byte processor through a
// single-entry output slot with a ready/write-enable handshake.
`timescale 1ns/1ps

module rx_byte_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxEn,
  input  logic       RxBitIn,
  input  logic       RxBitValid,
  input  logic       RxSE0,
  input  logic       processRxByteRdy,
  output logic [7:0] RxByteOut,
  output logic [7:0] RxCtrlOut,
  output logic       RxByteWEn,
  output logic       RxOverrun
);

  localparam int unsigned ByteW    = 8;
  localparam int unsigned CtrlW    = 8;
  localparam int unsigned BitCntW  = 4;
  localparam int unsigned OnesCntW = 3;

  localparam logic [CtrlW-1:0] CtrlStart    = CtrlW'(0);
  localparam logic [CtrlW-1:0] CtrlStop     = CtrlW'(1);
  localparam logic [CtrlW-1:0] CtrlStream   = CtrlW'(2);
  localparam logic [CtrlW-1:0] CtrlStuffErr = CtrlW'(3);

  // Six consecutive ones mean the next bit must be a stuffed zero.
  localparam logic [OnesCntW-1:0] OnesMax     = OnesCntW'(6);
  localparam logic [BitCntW-1:0]  LastBitIdx  = BitCntW'(ByteW - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RX       = 2'd1,
    WAIT_EOP = 2'd2
  } stateT;

  stateT               state;
  stateT               stateNext;
  logic [ByteW-1:0]    shiftReg;
  logic [ByteW-1:0]    shiftNext;
  logic [BitCntW-1:0]  bitCnt;
  logic [BitCntW-1:0]  bitCntNext;
  logic [OnesCntW-1:0] onesCnt;
  logic [OnesCntW-1:0] onesCntNext;
  logic                se0Prev;

  // Event request from the receive FSM toward the output slot.
  logic                queueReq;
  logic [ByteW-1:0]    queueByte;
  logic [CtrlW-1:0]    queueCtrl;
  logic                startPkt;

  // Output slot.
  logic                slotPending;
  logic [ByteW-1:0]    slotByte;
  logic [CtrlW-1:0]    slotCtrl;

  logic                se0Rise;
  logic                se0Fall;
  logic [ByteW-1:0]    byteWithBit;
  logic                slotIssue;
  logic                slotBusy;
  logic                slotLoad;
  logic                slotDrop;

  assign se0Rise = RxSE0 & ~se0Prev;
  assign se0Fall = ~RxSE0 & se0Prev;

  // Slot handshake: an issue frees the slot before a same-cycle event is queued.
  assign slotIssue = slotPending & processRxByteRdy;
  assign slotBusy  = slotPending & ~slotIssue;
  assign slotLoad  = queueReq & ~slotBusy;
  assign slotDrop  = queueReq & slotBusy;

  // Current byte with the incoming bit placed at the next LSB-first position.
  always_comb begin
    byteWithBit = shiftReg;
    byteWithBit[bitCnt[2:0]] = RxBitIn;
  end

  // Receive FSM state and bit-level datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      onesCnt  <= '0;
      se0Prev  <= 1'b0;
    end else begin
      state    <= stateNext;
      shiftReg <= shiftNext;
      bitCnt   <= bitCntNext;
      onesCnt  <= onesCntNext;
      se0Prev  <= RxSE0;
    end
  end

  // Next-state, destuffing, byte packing and event generation.
  always_comb begin
    stateNext   = state;
    shiftNext   = shiftReg;
    bitCntNext  = bitCnt;
    onesCntNext = onesCnt;
    queueReq    = 1'b0;
    queueByte   = '0;
    queueCtrl   = CtrlStart;
    startPkt    = 1'b0;

    if (!rxEn) begin
      stateNext   = IDLE;
      shiftNext   = '0;
      bitCntNext  = '0;
      onesCntNext = '0;
    end else begin
      case (state)
        IDLE: begin
          shiftNext   = '0;
          bitCntNext  = '0;
          onesCntNext = '0;
          if (RxBitValid && !RxSE0) begin
            queueReq    = 1'b1;
            queueCtrl   = CtrlStart;
            startPkt    = 1'b1;
            shiftNext   = ByteW'(RxBitIn);
            bitCntNext  = BitCntW'(1);
            onesCntNext = RxBitIn ? OnesCntW'(1) : '0;
            stateNext   = RX;
          end
        end

        RX: begin
          if (se0Rise) begin
            // End of packet wins over a coincident bit; partial bits are dropped.
            queueReq    = 1'b1;
            queueCtrl   = CtrlStop;
            shiftNext   = '0;
            bitCntNext  = '0;
            onesCntNext = '0;
            stateNext   = WAIT_EOP;
          end else if (RxBitValid) begin
            if (onesCnt == OnesMax) begin
              if (!RxBitIn) begin
                // Stuffed zero: discard without advancing the byte position.
                onesCntNext = '0;
              end else begin
                queueReq    = 1'b1;
                queueCtrl   = CtrlStuffErr;
                shiftNext   = '0;
                bitCntNext  = '0;
                onesCntNext = '0;
                stateNext   = WAIT_EOP;
              end
            end else begin
              onesCntNext = RxBitIn ? (onesCnt + OnesCntW'(1)) : '0;
              if (bitCnt == LastBitIdx) begin
                queueReq   = 1'b1;
                queueCtrl  = CtrlStream;
                queueByte  = byteWithBit;
                shiftNext  = '0;
                bitCntNext = '0;
              end else begin
                shiftNext  = byteWithBit;
                bitCntNext = bitCnt + BitCntW'(1);
              end
            end
          end
        end

        WAIT_EOP: begin
          // Leave once the line has returned from SE0 for one sample.
          if (se0Fall) begin
            stateNext = IDLE;
          end
        end

        default: begin
          stateNext   = IDLE;
          shiftNext   = '0;
          bitCntNext  = '0;
          onesCntNext = '0;
        end
      endcase
    end
  end

  // Output slot, write strobe and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      slotPending <= 1'b0;
      slotByte    <= '0;
      slotCtrl    <= '0;
      RxByteOut   <= '0;
      RxCtrlOut   <= '0;
      RxByteWEn   <= 1'b0;
      RxOverrun   <= 1'b0;
    end else begin
      RxByteWEn <= slotIssue;
      if (slotIssue) begin
        RxByteOut <= slotByte;
        RxCtrlOut <= slotCtrl;
      end

      if (slotLoad) begin
        slotPending <= 1'b1;
        slotByte    <= queueByte;
        slotCtrl    <= queueCtrl;
      end else begin
        slotPending <= slotBusy;
      end

      // A drop on the very start event still reports, so it outranks the clear.
      if (slotDrop) begin
        RxOverrun <= 1'b1;
      end else if (startPkt) begin
        RxOverrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rx_byte_assembler.sv
// tb_rx_byte_assembler: directed bit streams with hand-computed byte/ctrl
// events, compared against every write strobe the assembler produces.
`timescale 1ns/1ps

module tb_rx_byte_assembler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxEn;
  logic       RxBitIn;
  logic       RxBitValid;
  logic       RxSE0;
  logic       processRxByteRdy;
  logic [7:0] RxByteOut;
  logic [7:0] RxCtrlOut;
  logic       RxByteWEn;
  logic       RxOverrun;

  int nChecks = 0;
  int nErrors = 0;

  logic [15:0] gotQ[$];
  logic [15:0] expQ[$];

  rx_byte_assembler dut (
    .clk              (clk),
    .rst              (rst),
    .rxEn             (rxEn),
    .RxBitIn          (RxBitIn),
    .RxBitValid       (RxBitValid),
    .RxSE0            (RxSE0),
    .processRxByteRdy (processRxByteRdy),
    .RxByteOut        (RxByteOut),
    .RxCtrlOut        (RxCtrlOut),
    .RxByteWEn        (RxByteWEn),
    .RxOverrun        (RxOverrun)
  );

  always #5 clk = ~clk;

  // Capture every write strobe as {ctrl, byte}.
  always @(negedge clk) begin
    if (RxByteWEn === 1'b1) gotQ.push_back({RxCtrlOut, RxByteOut});
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendBit(input logic b);
    RxBitIn    = b;
    RxBitValid = 1'b1;
    tick(1);
    RxBitValid = 1'b0;
    tick(3);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) sendBit(b[i]);
  endtask

  task automatic sendEop();
    RxSE0 = 1'b1;
    tick(2);
    RxSE0 = 1'b0;
    tick(4);
  endtask

  task automatic expectEv(input logic [7:0] ctrl, input logic [7:0] data);
    expQ.push_back({ctrl, data});
  endtask

  task automatic compareEvents(input string tag);
    int n;
    check({tag, " count"}, 32'(gotQ.size()), 32'(expQ.size()));
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s ev%0d ctrl", tag, i), 32'(gotQ[i][15:8]), 32'(expQ[i][15:8]));
      check($sformatf("%s ev%0d byte", tag, i), 32'(gotQ[i][7:0]), 32'(expQ[i][7:0]));
    end
    gotQ.delete();
    expQ.delete();
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, " RxByteOut"}, 32'(RxByteOut), 32'h00);
    check({tag, " RxCtrlOut"}, 32'(RxCtrlOut), 32'h00);
    check({tag, " RxByteWEn"}, 32'(RxByteWEn), 32'h0);
    check({tag, " RxOverrun"}, 32'(RxOverrun), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    rxEn = 1'b1;
    RxBitIn = 1'b0;
    RxBitValid = 1'b0;
    RxSE0 = 1'b0;
    processRxByteRdy = 1'b1;
    tick(3);
    checkResetOutputs("reset");
    rst = 1'b0;
    tick(2);

    // SYNC + ACK PID
    sendByte(8'h80);
    sendByte(8'hD2);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80);
    expectEv(8'd2, 8'hD2); expectEv(8'd1, 8'h00);
    compareEvents("sync_ack");
    check("sync_ack overrun", 32'(RxOverrun), 32'h0);

    // 0xFF with a stuffed zero after six line ones (SYNC's final 1 counts)
    sendByte(8'h80);
    for (int i = 0; i < 5; i++) sendBit(1'b1);
    sendBit(1'b0);
    for (int i = 0; i < 3; i++) sendBit(1'b1);
    sendByte(8'hD2);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd2, 8'hFF);
    expectEv(8'd2, 8'hD2); expectEv(8'd1, 8'h00);
    compareEvents("stuffed_ff");

    // Seven line ones: stuff error, following bits ignored, then a new packet
    sendByte(8'h80);
    for (int i = 0; i < 6; i++) sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendEop();
    sendByte(8'h80);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd3, 8'h00);
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd1, 8'h00);
    compareEvents("stuff_err");

    // Stalled consumer through two completed bytes
    sendBit(1'b0);
    processRxByteRdy = 1'b0;
    for (int i = 0; i < 6; i++) sendBit(1'b0);
    sendBit(1'b1);
    sendByte(8'hD2);
    check("stall overrun set", 32'(RxOverrun), 32'h1);
    expectEv(8'd0, 8'h00);
    compareEvents("stall held");
    processRxByteRdy = 1'b1;
    tick(4);
    expectEv(8'd2, 8'h80);
    compareEvents("stall release");
    check("stall overrun sticky", 32'(RxOverrun), 32'h1);
    sendEop();
    expectEv(8'd1, 8'h00);
    compareEvents("stall eop");
    sendBit(1'b0);
    check("overrun cleared on start", 32'(RxOverrun), 32'h0);
    for (int i = 0; i < 6; i++) sendBit(1'b0);
    sendBit(1'b1);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd1, 8'h00);
    compareEvents("after stall");

    // SE0 after three bits of a byte
    sendByte(8'h80);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd1, 8'h00);
    compareEvents("partial");

    // Bit strobe coincident with SE0 rising
    sendByte(8'h80);
    sendBit(1'b1); sendBit(1'b1);
    RxBitIn = 1'b1;
    RxBitValid = 1'b1;
    RxSE0 = 1'b1;
    tick(1);
    RxBitValid = 1'b0;
    tick(1);
    RxSE0 = 1'b0;
    tick(4);
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd1, 8'h00);
    compareEvents("se0_with_bit");

    // rxEn dropped mid-byte, then a fresh packet
    sendByte(8'h80);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    rxEn = 1'b0;
    tick(2);
    rxEn = 1'b1;
    tick(2);
    sendByte(8'h80);
    sendEop();
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80);
    expectEv(8'd0, 8'h00); expectEv(8'd2, 8'h80); expectEv(8'd1, 8'h00);
    compareEvents("rxen_abort");

    // Reset mid-byte with the slot pending
    processRxByteRdy = 1'b0;
    sendByte(8'h80);
    sendBit(1'b0); sendBit(1'b1);
    check("pre-reset overrun", 32'(RxOverrun), 32'h1);
    compareEvents("pre-reset");
    rst = 1'b1;
    tick(1);
    checkResetOutputs("mid reset");
    rst = 1'b0;
    processRxByteRdy = 1'b1;
    tick(12);
    compareEvents("post-reset");
    check("post-reset WEn", 32'(RxByteWEn), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/rx_byte_assembler.md
# rx_byte_assembler

Receive byte assembler for the USB serial interface engine. It takes NRZI-decoded bits from the line receiver, removes stuffed bits, and detects bit-stuff violations and EOP. It packs bits LSB-first into bytes and delivers each byte with a control code to the receive byte processor over a ready/write-enable handshake. It sits directly between the wire decoder and the PID/CRC processing stage.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- rxEn  in  1  receive enable; 0 forces IDLE at the next edge
- RxBitIn  in  1  NRZI-decoded bit (1 = no line transition)
- RxBitValid  in  1  one-cycle strobe qualifying RxBitIn
- RxSE0  in  1  level; line is in SE0
- processRxByteRdy  in  1  downstream ready to accept one byte
- RxByteOut  out  8  assembled byte or 0x00 for control events
- RxCtrlOut  out  8  0 = DATA_START, 1 = DATA_STOP, 2 = DATA_STREAM, 3 = DATA_BIT_STUFF_ERROR
- RxByteWEn  out  1  one-cycle write strobe to downstream
- RxOverrun  out  1  sticky; an event was dropped because the output slot was still full

## Operation
- States: IDLE, RX, WAIT_EOP.
- Output slot: one pending register holding byte, ctrl and a pending flag.
- Issuing from the slot: if pending=1 and processRxByteRdy=1, drive RxByteWEn=1 for exactly one cycle with the slot contents, and clear pending in the same edge.
- Queuing an event sets pending. If pending is already 1, the event is dropped and RxOverrun is set.
- IDLE:
  - On the first RxBitValid with RxSE0=0: queue {0x00, ctrl 0}.
  - Load this first bit into the shift register as bit 0; bitCnt=1.
  - Set onesCnt = RxBitIn ? 1 : 0. Clear RxOverrun. Go to RX.
- RX, on RxBitValid:
  - Stuffed-bit case (onesCnt==6):
    - RxBitIn=0: discard the bit, onesCnt=0, bitCnt unchanged.
    - RxBitIn=1: queue {0x00, ctrl 3} and go to WAIT_EOP.
  - Otherwise: shift the bit into position bitCnt (LSB first) and increment bitCnt.
    - onesCnt = RxBitIn ? onesCnt+1 : 0.
    - When bitCnt reaches 8, queue {byte, ctrl 2} and set bitCnt=0.
- RX, on a rising edge of RxSE0 (RxSE0=1, previous sample 0):
  - Queue {0x00, ctrl 1}. Discard partial bits (bitCnt ≠ 0 is not flagged).
  - Go to WAIT_EOP.
- WAIT_EOP: ignore bits. When RxSE0 has been 0 for one sampled cycle, go to IDLE.
- Simultaneous events:
  - RxSE0 rising and RxBitValid in the same cycle: SE0 wins and the bit is ignored.
  - Queue and issue in the same cycle: the issue empties the slot first, so the new event is accepted, not dropped.
- rxEn=0 or rst mid-packet: go to IDLE and drop any partial byte. A pending slot is cleared only by rst.
- Counter widths: bitCnt 3 bits plus a terminal flag (or 4 bits); onesCnt 3 bits, saturating at 6.

## Timing
- Reset values:
  - RxByteOut=0x00, RxCtrlOut=0x00, RxByteWEn=0, RxOverrun=0.
  - State IDLE; pending, bitCnt, onesCnt and the SE0 history register all 0.
- Latency: the event is registered at the edge after the completing RxBitValid. RxByteWEn rises one cycle later at the earliest, given processRxByteRdy=1.
- RxByteOut and RxCtrlOut hold their values until the next issue.
- processRxByteRdy is a registered signal that falls one cycle after an accepted strobe. No extra gap is needed: the slot is already empty when Rdy falls.
- Minimum RxBitValid spacing is 4 clocks. The downstream returns Rdy within 4 cycles of each strobe, so overrun occurs only on a stalled consumer.

## Test plan
- SYNC + ACK (bits 0000000 1, 01001011 LSB-first, then SE0): emits ctrl0/0x00, ctrl2/0x80, ctrl2/0xD2, ctrl1/0x00, each as a single WEn pulse.
- Stuffed data byte 0xFF (eight 1s with a 0 inserted after six): emits ctrl2/0xFF. The inserted 0 is not counted, and the next byte aligns correctly.
- Seven consecutive 1s after SYNC: emits ctrl3/0x00. Further bits are ignored until SE0 deasserts, then IDLE. A later packet starts with ctrl0.
- processRxByteRdy held 0 through two completed bytes: the first byte is held; RxOverrun=1 and the second is dropped. Releasing Rdy gives one WEn with the first byte.
- SE0 after 3 bits of a byte: ctrl1 is emitted and the partial byte is discarded. The same-cycle RxBitValid+RxSE0 case gives ctrl1 only.
- rst asserted mid-byte with the slot pending: all outputs return to reset values, and no WEn fires afterwards.
